// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot program loader.
//   byte_in / byte_valid / byte_ready : valid/ready byte stream into the loader
//   mem_we / mem_addr / mem_wdata     : word writes out of the loader
// master: the system side (byte source, memory sink). slave: the loader.
interface prog_loader_if #(
    parameter int AW = 15
);
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives a frame of
//   count_hi, count_lo, 2*N data bytes, xor-checksum byte
// packs the data big-endian into 16-bit words written to instruction memory
// from address 0 upward, and releases the core reset only once the checksum
// matches.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : byte stream in, memory write bus out (slave modport)
//   core_rst  : reset to the core, low only after a successful load
//   done, err : sticky load result flags
//
// state  | meaning
// CNT_HI | waiting for word-count high byte
// CNT_LO | waiting for word-count low byte, range check
// D_HI   | waiting for first (high) byte of a word
// D_LO   | waiting for second (low) byte of a word
// WR     | writing the assembled word
// CHK    | waiting for checksum byte
// DONE   | image loaded, core released (terminal)
// ERR    | oversize header or bad checksum (terminal)
module prog_loader #(
    parameter int MAX_WORDS = 16384,
    parameter int AW        = 15
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus,
    output logic          core_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        CNT_HI, CNT_LO, D_HI, D_LO, WR, CHK, DONE, ERR
    } state_t;

    state_t        state, state_n;
    logic [15:0]   count;
    logic [15:0]   count_full;
    logic [7:0]    hi, lo, chk;
    logic [AW-2:0] idx;
    logic          accept;

    assign accept        = bus.byte_valid && bus.byte_ready;
    assign bus.mem_addr  = {idx, 1'b0};
    assign bus.mem_wdata = {hi, lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CNT_HI;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n        = state;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        core_rst       = 1'b1;
        done           = 1'b0;
        err            = 1'b0;
        count_full     = {count[15:8], bus.byte_in};
        case (state)
            CNT_HI: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) state_n = CNT_LO;
            end
            CNT_LO: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    if (32'(count_full) > MAX_WORDS) state_n = ERR;
                    else if (count_full == 16'd0)    state_n = CHK;
                    else                             state_n = D_HI;
                end
            end
            D_HI: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) state_n = D_LO;
            end
            D_LO: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) state_n = WR;
            end
            WR: begin
                bus.mem_we = 1'b1;
                // idx is the index being written now; last word is N-1
                if (32'(idx) + 32'd1 == 32'(count)) state_n = CHK;
                else                                state_n = D_HI;
            end
            CHK: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    if (bus.byte_in == chk) state_n = DONE;
                    else                    state_n = ERR;
                end
            end
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: state_n = CNT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            chk   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                CNT_HI: if (accept) count[15:8] <= bus.byte_in;
                CNT_LO: if (accept) begin
                    count[7:0] <= bus.byte_in;
                    chk        <= '0;
                    idx        <= '0;
                end
                D_HI: if (accept) begin
                    hi  <= bus.byte_in;
                    chk <= chk ^ bus.byte_in;
                end
                D_LO: if (accept) begin
                    lo  <= bus.byte_in;
                    chk <= chk ^ bus.byte_in;
                end
                WR: idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam int AW        = 15;
    localparam int MAX_WORDS = 16384;

    logic clk = 1'b0;
    logic rst;
    logic core_rst, done, err;

    prog_loader_if #(.AW(AW)) bus();

    prog_loader #(.MAX_WORDS(MAX_WORDS), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] b;
        int          len;
        int          gap;
        logic        exp_done;
        logic        exp_err;
        int          exp_nwr;
        int          exp_acc;
        int          exp_cyc;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] frame[$];
    int wr_addr[$];
    int wr_data[$];
    int acc_n, done_cyc, wr_ready_bad;
    bit timed_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [95:0] b, input int len, input int gap,
                                input logic d, input logic e, input int nwr,
                                input int acc, input int cyc);
        vec_t v;
        v.b = b; v.len = len; v.gap = gap; v.exp_done = d; v.exp_err = e;
        v.exp_nwr = nwr; v.exp_acc = acc; v.exp_cyc = cyc;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; each iteration observes the current cycle, then
    // drives the byte sampled at the next rising edge.
    task automatic drive(input int gap_pct, input bit stop_when_empty, input int budget);
        int cyc = 0;
        wr_addr.delete();
        wr_data.delete();
        acc_n = 0; done_cyc = -1; wr_ready_bad = 0; timed_out = 0;
        forever begin
            if (bus.mem_we) begin
                wr_addr.push_back(int'(bus.mem_addr));
                wr_data.push_back(int'(bus.mem_wdata));
                if (bus.byte_ready) wr_ready_bad++;
            end
            if ((done || err) && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc - done_cyc >= 4) break;
            if (stop_when_empty && tx_q.size() == 0) break;
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            if (tx_q.size() > 0 && int'($urandom_range(99, 0)) >= gap_pct) begin
                bus.byte_valid = 1'b1;
                bus.byte_in = tx_q[0];
                if (bus.byte_ready) begin
                    void'(tx_q.pop_front());
                    acc_n++;
                end
            end else begin
                bus.byte_valid = 1'b0;
                bus.byte_in = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.byte_valid = 1'b0;
    endtask

    // Reference: decode the whole frame from the protocol rules and compare
    // against what the run logged.
    task automatic model_check(input string name);
        int n;
        logic [7:0] x;
        logic exp_done, exp_err;
        int exp_acc, exp_nwr;
        n = int'({frame[0], frame[1]});
        x = 8'h00;
        if (n > MAX_WORDS) begin
            exp_done = 0; exp_err = 1; exp_acc = 2; exp_nwr = 0;
        end else begin
            for (int i = 0; i < 2 * n; i++) x ^= frame[2 + i];
            exp_done = (x == frame[2 + 2 * n]);
            exp_err = !exp_done;
            exp_acc = 2 * n + 3;
            exp_nwr = n;
        end
        check({name, " timeout"}, 32'(timed_out), 32'd0);
        check({name, " done"}, 32'(done), 32'(exp_done));
        check({name, " err"}, 32'(err), 32'(exp_err));
        check({name, " core_rst"}, 32'(core_rst), 32'(!exp_done));
        check({name, " accepted"}, 32'(acc_n), 32'(exp_acc));
        check({name, " nwrites"}, 32'(wr_addr.size()), 32'(exp_nwr));
        check({name, " ready_in_wr"}, 32'(wr_ready_bad), 32'd0);
        check({name, " ready_terminal"}, 32'(bus.byte_ready), 32'd0);
        for (int i = 0; i < exp_nwr && i < wr_addr.size(); i++) begin
            check({name, " waddr"}, 32'(wr_addr[i]), 32'(2 * i));
            check({name, " wdata"}, 32'(wr_data[i]), 32'({frame[2 + 2 * i], frame[3 + 2 * i]}));
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mk(96'h0002_1234_ABCD_4000_0000_0000, 7, 0, 1, 0, 2, 7, 9);
        vecs[1] = mk(96'h0002_1234_ABCD_4100_0000_0000, 7, 0, 0, 1, 2, 7, 9);
        vecs[2] = mk(96'h0000_0000_0000_0000_0000_0000, 3, 0, 1, 0, 0, 3, 3);
        vecs[3] = mk(96'h0000_0100_0000_0000_0000_0000, 3, 0, 0, 1, 0, 3, 3);
        vecs[4] = mk(96'h4001_1234_0000_0000_0000_0000, 4, 0, 0, 1, 0, 2, 2);
        vecs[5] = mk(96'h0004_0102_0304_0506_0708_0800, 11, 40, 1, 0, 4, 11, -1);
        vecs[6] = mk(96'hFFFF_0000_0000_0000_0000_0000, 3, 0, 0, 1, 0, 2, 2);
        vecs[7] = mk(96'h0001_BEEF_5100_0000_0000_0000, 5, 0, 1, 0, 1, 5, 6);

        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        #2;
        check("rst byte_ready", 32'(bus.byte_ready), 32'd1);
        check("rst mem_we", 32'(bus.mem_we), 32'd0);
        check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst core_rst", 32'(core_rst), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);

        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            do_reset();
            frame.delete();
            tx_q.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                frame.push_back(vecs[v].b[95 - 8 * i -: 8]);
                tx_q.push_back(vecs[v].b[95 - 8 * i -: 8]);
            end
            drive(vecs[v].gap, 1'b0, 2000);
            check({nm, " done"}, 32'(done), 32'(vecs[v].exp_done));
            check({nm, " err"}, 32'(err), 32'(vecs[v].exp_err));
            check({nm, " nwrites"}, 32'(wr_addr.size()), 32'(vecs[v].exp_nwr));
            check({nm, " accepted"}, 32'(acc_n), 32'(vecs[v].exp_acc));
            if (vecs[v].exp_cyc >= 0)
                check({nm, " cycles"}, 32'(done_cyc), 32'(vecs[v].exp_cyc));
            if (vecs[v].len >= 2 && int'({frame[0], frame[1]}) <= MAX_WORDS || vecs[v].exp_err)
                model_check(nm);
        end

        for (int r = 0; r < 12; r++) begin
            int n;
            logic [7:0] x;
            logic [7:0] d;
            n = int'($urandom_range(6, 1));
            frame.delete();
            frame.push_back(8'h00);
            frame.push_back(8'(n));
            x = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
                d = 8'($urandom);
                x ^= d;
                frame.push_back(d);
            end
            if ($urandom_range(3, 0) == 0) x ^= 8'h5A;
            frame.push_back(x);
            tx_q = frame;
            do_reset();
            drive(int'($urandom_range(60, 0)), 1'b0, 2000);
            model_check($sformatf("rand%0d", r));
        end

        // Abort mid-word: reset after the 3rd data byte, then a fresh frame.
        do_reset();
        tx_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        drive(0, 1'b1, 200);
        check("abort1 nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_data.size() > 0) check("abort1 wdata", 32'(wr_data[0]), 32'h1122);
        #2 rst = 1'b1;
        #1;
        check("abort1 mem_we", 32'(bus.mem_we), 32'd0);
        check("abort1 core_rst", 32'(core_rst), 32'd1);
        check("abort1 byte_ready", 32'(bus.byte_ready), 32'd1);
        check("abort1 done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        tx_q = frame;
        drive(20, 1'b0, 500);
        model_check("abort1 refill");

        // Abort while the write strobe is up: it must drop without a clock.
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        drive(0, 1'b1, 200);
        check("abort2 in_wr", 32'(bus.mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort2 mem_we", 32'(bus.mem_we), 32'd0);
        check("abort2 mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort2 mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame = '{8'h00, 8'h00, 8'h00};
        tx_q = frame;
        drive(0, 1'b0, 200);
        check("abort2 cycles", 32'(done_cyc), 32'd3);
        model_check("abort2 empty");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
